// File: rtl/pulse_cmd_sequencer.sv
// Framed UART command parser driving a timed high/low pulse engine on o_Out.
// Define PULSE_CMD_ACK_TX_EN to echo an accept/reject byte to a UART transmitter.
module pulse_cmd_sequencer #(
  parameter int          CLKS_PER_TICK = 10,
  parameter int          TIMEOUT_TICKS = 10000,
  parameter logic [15:0] DEF_HIGH      = 16'd500,
  parameter logic [15:0] DEF_LOW       = 16'd500
) (
  input  logic       r_Clock,
  input  logic       r_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Out,
  output logic       o_Busy,
  output logic       o_Cmd_Ack,
  output logic       o_Frame_Err,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_TICK - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {P_HUNT, P_CMD, P_DHI, P_DLO, P_CHK} pstate_t;
  typedef enum logic [1:0] {E_OFF, E_HIGH, E_LOW, E_FORCED} estate_t;

  pstate_t       pst_q, pst_d;
  estate_t       est_q, est_d;
  logic [7:0]    cmd_q, cmd_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [TW-1:0] to_q, to_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tmr_q, tmr_d, high_q, high_d, low_q, low_d, rep_q, rep_d;
  logic          out_q, out_d, busy_q, ack_q, ack_d, err_q, err_d;

  logic        tick;
  logic [15:0] data;

  assign tick = (presc_q == PRESC_MAX);
  assign data = {dhi_q, dlo_q};

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path through this block can infer a latch.
    pst_d   = pst_q;
    est_d   = est_q;
    cmd_d   = cmd_q;
    dhi_d   = dhi_q;
    dlo_d   = dlo_q;
    to_d    = to_q;
    tmr_d   = tmr_q;
    high_d  = high_q;
    low_d   = low_q;
    rep_d   = rep_q;
    out_d   = out_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    presc_d = tick ? '0 : presc_q + 1'b1;

    // Engine phase boundaries; each phase runs on the length latched when it began.
    if (tick && (est_q == E_HIGH || est_q == E_LOW)) begin
      if (tmr_q > 16'd1) begin
        tmr_d = tmr_q - 16'd1;
      end else if (est_q == E_HIGH) begin
        est_d = E_LOW;
        out_d = 1'b0;
        tmr_d = low_q;
      end else if (rep_q == 16'd1) begin
        est_d = E_OFF;
        out_d = 1'b0;
      end else begin
        if (rep_q > 16'd1) rep_d = rep_q - 16'd1;
        est_d = E_HIGH;
        out_d = 1'b1;
        tmr_d = high_q;
      end
    end

    if (i_Rx_DV) begin
      to_d = '0;
      unique case (pst_q)
        P_HUNT: if (i_Rx_Byte == 8'hA5) pst_d = P_CMD;
        P_CMD: begin cmd_d = i_Rx_Byte; pst_d = P_DHI; end
        P_DHI: begin dhi_d = i_Rx_Byte; pst_d = P_DLO; end
        P_DLO: begin dlo_d = i_Rx_Byte; pst_d = P_CHK; end
        P_CHK: begin
          pst_d = P_HUNT;
          // Command execution overrides any engine transition computed above.
          if (i_Rx_Byte != (cmd_q ^ dhi_q ^ dlo_q)) begin
            err_d = 1'b1;
          end else begin
            case (cmd_q)
              8'h01: if (data == 16'd0) err_d = 1'b1;
                     else begin high_d = data; ack_d = 1'b1; end
              8'h02: if (data == 16'd0) err_d = 1'b1;
                     else begin low_d = data; ack_d = 1'b1; end
              8'h03: if (high_q == 16'd0 || low_q == 16'd0) err_d = 1'b1;
                     else begin
                       rep_d   = data;
                       est_d   = E_HIGH;
                       out_d   = 1'b1;
                       tmr_d   = high_q;
                       presc_d = '0;
                       ack_d   = 1'b1;
                     end
              8'h04: begin est_d = E_OFF; out_d = 1'b0; ack_d = 1'b1; end
              8'h05: begin est_d = E_FORCED; out_d = data[0]; ack_d = 1'b1; end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: pst_d = P_HUNT;
      endcase
    end else if (pst_q != P_HUNT) begin
      if (to_q == TO_MAX) begin
        err_d = 1'b1;
        pst_d = P_HUNT;
        to_d  = '0;
      end else if (tick) begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge r_Clock or negedge r_Rst_n) begin
    if (!r_Rst_n) begin
      pst_q   <= P_HUNT;
      est_q   <= E_OFF;
      cmd_q   <= '0;
      dhi_q   <= '0;
      dlo_q   <= '0;
      to_q    <= '0;
      presc_q <= '0;
      tmr_q   <= '0;
      high_q  <= DEF_HIGH;
      low_q   <= DEF_LOW;
      rep_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register sample the same pre-edge values.
      pst_q   <= pst_d;
      est_q   <= est_d;
      cmd_q   <= cmd_d;
      dhi_q   <= dhi_d;
      dlo_q   <= dlo_d;
      to_q    <= to_d;
      presc_q <= presc_d;
      tmr_q   <= tmr_d;
      high_q  <= high_d;
      low_q   <= low_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      busy_q  <= (est_d == E_HIGH) || (est_d == E_LOW);
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign o_Out       = out_q;
  assign o_Busy      = busy_q;
  assign o_Cmd_Ack   = ack_q;
  assign o_Frame_Err = err_q;

`ifdef PULSE_CMD_ACK_TX_EN
  logic       tx_pend_q, tx_pend_d, tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;

  // A fresh result replaces any unsent echo and defers sending by one cycle.
  always_comb begin
    tx_pend_d = tx_pend_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    if (ack_d || err_d) begin
      tx_pend_d = 1'b1;
      tx_byte_d = ack_d ? 8'h5A : 8'hEE;
    end else if (tx_pend_q && !i_Tx_Active) begin
      tx_pend_d = 1'b0;
      tx_dv_d   = 1'b1;
    end
  end

  always_ff @(posedge r_Clock or negedge r_Rst_n) begin
    if (!r_Rst_n) begin
      tx_pend_q <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_pend_q <= tx_pend_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
`else
  logic unused_tx_active;
  assign unused_tx_active = i_Tx_Active;
  assign o_Tx_DV          = 1'b0;
  assign o_Tx_Byte        = 8'h00;
`endif

endmodule

// File: tb/tb_pulse_cmd_sequencer.sv
// Scoreboard bench for pulse_cmd_sequencer: a cycle-level behavioural model predicts
// o_Out/o_Busy and queues expected accept/reject pulses that a monitor checks.
module tb_pulse_cmd_sequencer;
  localparam int CPT = 4;
  localparam int TOT = 60;

  logic       clk = 1'b0, rst_n = 1'b0, rx_dv = 1'b0, tx_active = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       o_out, o_busy, o_ack, o_err, o_tx_dv;
  logic [7:0] o_tx_byte;

  always #5 clk = ~clk;

  pulse_cmd_sequencer #(.CLKS_PER_TICK(CPT), .TIMEOUT_TICKS(TOT)) dut (
    .r_Clock(clk), .r_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Out(o_out), .o_Busy(o_busy), .o_Cmd_Ack(o_ack), .o_Frame_Err(o_err),
    .o_Tx_DV(o_tx_dv), .o_Tx_Byte(o_tx_byte), .i_Tx_Active(tx_active));

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { bit is_ack; int lo; int hi; } resp_t;
  resp_t      sb[$];
  logic [7:0] fr[$];
  int  cyc = 0, idle = 0;
  int  m_high = 500, m_low = 500, m_rep = 0, m_rem = 0;
  int  m_phase = 0;          // 0 off, 1 high, 2 low, 3 forced
  bit  m_lvl = 1'b0;

  function automatic bit m_out();
    return (m_phase == 1) || (m_phase == 3 && m_lvl);
  endfunction

  task automatic execute(input logic [7:0] cmd, input logic [15:0] d, input logic [7:0] chk);
    bit ok;
    ok = (chk == (cmd ^ d[15:8] ^ d[7:0]));
    if (ok) begin
      case (cmd)
        8'h01: if (d == 0) ok = 0; else m_high = int'(d);
        8'h02: if (d == 0) ok = 0; else m_low = int'(d);
        8'h03: if (m_high == 0 || m_low == 0) ok = 0;
               else begin m_rep = int'(d); m_phase = 1; m_rem = m_high * CPT; end
        8'h04: m_phase = 0;
        8'h05: begin m_phase = 3; m_lvl = d[0]; end
        default: ok = 0;
      endcase
    end
    sb.push_back('{ok, cyc, cyc});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_high = 500; m_low = 500; m_rep = 0; m_rem = 0; m_phase = 0; m_lvl = 0;
      idle = 0; sb.delete(); fr.delete();
    end else begin
      cyc++;
      if (m_phase == 1 || m_phase == 2) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_phase == 1) begin m_phase = 2; m_rem = m_low * CPT; end
          else if (m_rep == 1) m_phase = 0;
          else begin
            if (m_rep > 1) m_rep--;
            m_phase = 1; m_rem = m_high * CPT;
          end
        end
      end
      if (rx_dv) begin
        idle = 0;
        if (fr.size() == 0) begin
          if (rx_byte == 8'hA5) fr.push_back(rx_byte);
        end else begin
          fr.push_back(rx_byte);
          if (fr.size() == 5) begin
            execute(fr[1], {fr[2], fr[3]}, fr[4]);
            fr.delete();
          end
        end
      end else if (fr.size() != 0) begin
        idle++;
        // Tick phase is unknown to the model, so the timeout lands in a one-tick window.
        if (idle == (TOT - 1) * CPT + 1) begin
          sb.push_back('{1'b0, cyc + 1, cyc + CPT});
          fr.delete();
          idle = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit         tx_unsent = 0;
  logic [7:0] tx_exp = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      resp_t e;
      bit    act_now;
      act_now = tx_active;
      check("out", int'(o_out), int'(m_out()));
      check("busy", int'(o_busy), int'(m_phase == 1 || m_phase == 2));
      if (o_ack || o_err) begin
        if (sb.size() == 0) check("unexpected_resp", int'({o_ack, o_err}), 0);
        else begin
          e = sb.pop_front();
          check("resp_kind", int'({o_ack, o_err}), e.is_ack ? 2 : 1);
          check("resp_not_early", int'(cyc >= e.lo), 1);
          check("resp_not_late", int'(cyc <= e.hi), 1);
        end
      end else if (sb.size() > 0 && sb[0].hi < cyc) begin
        e = sb.pop_front();
        check("resp_missing", int'({o_ack, o_err}), e.is_ack ? 2 : 1);
      end
`ifdef PULSE_CMD_ACK_TX_EN
      if (o_ack || o_err) check("tx_dv_on_result", int'(o_tx_dv), 0);
      else if (tx_unsent && !act_now) begin
        check("tx_dv", int'(o_tx_dv), 1);
        check("tx_byte", int'(o_tx_byte), int'(tx_exp));
      end else check("tx_dv_idle", int'(o_tx_dv), 0);
      if (o_tx_dv) tx_unsent = 0;
      if (o_ack || o_err) begin tx_unsent = 1; tx_exp = o_ack ? 8'h5A : 8'hEE; end
      tx_active = ($urandom_range(0, 2) == 0);
`else
      if (act_now) tx_active = 1'b0;
      check("tx_dv_tied", int'(o_tx_dv), 0);
      check("tx_byte_tied", int'(o_tx_byte), 0);
`endif
    end else begin
      tx_unsent = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] d, input bit bad, input int gap);
    logic [7:0] chk;
    chk = cmd ^ d[15:8] ^ d[7:0] ^ (bad ? 8'h01 : 8'h00);
    send_byte(8'hA5, gap);
    send_byte(cmd, gap);
    send_byte(d[15:8], gap);
    send_byte(d[7:0], gap);
    send_byte(chk, gap);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out", int'(o_out), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ack", int'(o_ack), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_tx_dv", int'(o_tx_dv), 0);
    wait_cycles(3);

    // Default 500-tick phases, two repetitions, then idle.
    send_frame(8'h03, 16'd2, 0, 0);
    wait_cycles(4 * 500 * CPT + 20);
    check("rep2_done_busy", int'(o_busy), 0);
    check("rep2_done_out", int'(o_out), 0);

    // Continuous 10/20 ticks, then STOP mid-HIGH.
    send_frame(8'h01, 16'd10, 0, 1);
    send_frame(8'h02, 16'd20, 0, 1);
    send_frame(8'h03, 16'd0, 0, 1);
    wait_cycles(500);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_phase == 1 && m_rem > 30) break;
    end
    send_frame(8'h04, 16'd0, 0, 0);
    wait_cycles(20);

    // Bad checksum leaves high_time alone; next valid frame is accepted.
    send_frame(8'h01, 16'd7, 1, 2);
    send_frame(8'h03, 16'd1, 0, 2);
    wait_cycles(30 * CPT + 20);

    // Inter-byte timeout, then a fresh frame.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    wait_cycles(TOT * CPT + 3 * CPT);
    send_frame(8'h05, 16'd1, 0, 1);
    wait_cycles(10);

    // Illegal parameter, unknown command, stray bytes ahead of a frame.
    send_frame(8'h02, 16'd0, 0, 1);
    send_frame(8'h07, 16'd0, 0, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_frame(8'h04, 16'd0, 0, 1);
    wait_cycles(10);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: send_frame(8'h01, 16'($urandom_range(0, 11)), ($urandom_range(0, 7) == 0), $urandom_range(0, 8));
        2, 3: send_frame(8'h02, 16'($urandom_range(0, 11)), ($urandom_range(0, 7) == 0), $urandom_range(0, 8));
        4, 5: send_frame(8'h03, 16'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom_range(0, 8));
        6:    send_frame(8'h04, 16'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 8));
        7:    send_frame(8'h05, 16'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom_range(0, 8));
        8:    send_frame(8'($urandom_range(6, 255)), 16'($urandom), 0, $urandom_range(0, 8));
        default: begin
          send_byte(8'hA5, 1);
          for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(8'($urandom), 1);
          wait_cycles(TOT * CPT + 3 * CPT);
        end
      endcase
      wait_cycles($urandom_range(0, 100));
    end

    // Reset mid-HIGH, then confirm defaults by a single default-length period.
    send_frame(8'h01, 16'd3, 0, 0);
    send_frame(8'h03, 16'd0, 0, 0);
    wait_cycles(5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out", int'(o_out), 0);
    check("rst_mid_busy", int'(o_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(3);
    send_frame(8'h03, 16'd1, 0, 0);
    wait_cycles(2 * 500 * CPT + 20);
    check("final_busy", int'(o_busy), 0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
